// File: rtl/mips_mem_pkg.sv
// Shared address map, register selectors and status-bit layout for the
// processor memory responder.
package mips_mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CON_W  = 8;

  // Region decode: RAM on adr[31:16], MMIO on adr[31:4]
  localparam logic [15:0] RAM_REGION_HI  = 16'h0000;
  localparam logic [27:0] MMIO_REGION_HI = 28'hFFFF000;

  localparam logic [31:0] ADDR_LED      = 32'hFFFF_0000;
  localparam logic [31:0] ADDR_CYCLE    = 32'hFFFF_0004;
  localparam logic [31:0] ADDR_CON_TX   = 32'hFFFF_0008;
  localparam logic [31:0] ADDR_CON_STAT = 32'hFFFF_000C;

  localparam int unsigned STAT_EMPTY_BIT = 0;
  localparam int unsigned STAT_FULL_BIT  = 1;
  localparam int unsigned STAT_OVF_BIT   = 2;

  typedef enum logic [1:0] {
    REG_LED      = 2'd0,
    REG_CYCLE    = 2'd1,
    REG_CON_TX   = 2'd2,
    REG_CON_STAT = 2'd3
  } mmio_reg_e;

  function automatic mmio_reg_e mmio_reg(input logic [31:0] a);
    return mmio_reg_e'(a[3:2]);
  endfunction

endpackage

// File: rtl/con_fifo.sv
// Console transmit FIFO; a push into a full FIFO is accepted only when the
// head is popped on the same edge.
module con_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          push_ok, pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  // Gate the head so the output reads zero whenever nothing is queued
  assign data    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mips_mem_resp.sv
// Processor-side memory responder: word RAM, LED/cycle/console MMIO and a
// console TX FIFO drained by an external ready/valid sink.
module mips_mem_resp
  import mips_mem_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] adr,
  input  logic [WORD_W-1:0] writedata,
  input  logic              memwrite,
  output logic [WORD_W-1:0] readdata,
  output logic [CON_W-1:0]  led,
  output logic [CON_W-1:0]  con_data,
  output logic              con_valid,
  input  logic              con_ready
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic [WORD_W-1:0] ram [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx;
  logic [WORD_W-1:0] cycle_q;
  logic              overflow;
  logic              is_ram, is_mmio;
  mmio_reg_e         reg_sel;
  logic              ram_we, led_we, tx_push, stat_clr;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [CNT_W-1:0]  unused_fifo_count;
  logic              unused_adr_bits;

  assign is_ram   = (adr[31:16] == RAM_REGION_HI);
  assign is_mmio  = (adr[31:4] == MMIO_REGION_HI);
  assign reg_sel  = mmio_reg(adr);
  assign ram_idx  = adr[RAM_AW+1:2];
  assign unused_adr_bits = ^{adr[15:RAM_AW+2], adr[1:0]};

  assign ram_we   = memwrite & is_ram;
  assign led_we   = memwrite & is_mmio & (reg_sel == REG_LED);
  assign tx_push  = memwrite & is_mmio & (reg_sel == REG_CON_TX);
  assign stat_clr = memwrite & is_mmio & (reg_sel == REG_CON_STAT);

  assign con_valid = ~fifo_empty;
  assign fifo_pop  = con_ready & ~fifo_empty;

  // Zero-latency read mux; unmapped and write-only locations read as zero
  always_comb begin
    readdata = '0;
    if (is_ram) begin
      readdata = ram[ram_idx];
    end else if (is_mmio) begin
      case (reg_sel)
        REG_LED:      readdata = WORD_W'(led);
        REG_CYCLE:    readdata = cycle_q;
        REG_CON_STAT: begin
          readdata[STAT_EMPTY_BIT] = fifo_empty;
          readdata[STAT_FULL_BIT]  = fifo_full;
          readdata[STAT_OVF_BIT]   = overflow;
        end
        default:      readdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= writedata;
  end

  // Clear wins over a coincident drop so software never misses its own ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led      <= '0;
      cycle_q  <= '0;
      overflow <= 1'b0;
    end else begin
      cycle_q <= cycle_q + WORD_W'(1);
      if (led_we) led <= writedata[CON_W-1:0];
      if (stat_clr)
        overflow <= 1'b0;
      else if (tx_push & fifo_full & ~fifo_pop)
        overflow <= 1'b1;
    end
  end

  con_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (CON_W)
  ) u_con_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (writedata[CON_W-1:0]),
    .pop       (fifo_pop),
    .data      (con_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (unused_fifo_count)
  );

endmodule

// File: doc/mips_mem_resp.md
MIPS_MEM_RESP -- requirements
Module: mips_mem_resp

Interface
REQ-001 SHALL have parameter RAM_WORDS, 64, number of 32-bit RAM words (power of two).
REQ-002 SHALL have parameter FIFO_DEPTH, 4, number of console TX FIFO entries (power of two).
REQ-003 SHALL have port clk  input  1  system clock, rising-edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port adr  input  32  byte address from the processor.
REQ-006 SHALL have port writedata  input  32  store data from the processor.
REQ-007 SHALL have port memwrite  input  1  store strobe, sampled at rising clk edge.
REQ-008 SHALL have port readdata  output  32  load/fetch data, combinational from adr.
REQ-009 SHALL have port led  output  8  LED register contents.
REQ-010 SHALL have port con_data  output  8  console byte at FIFO head.
REQ-011 SHALL have port con_valid  output  1  FIFO non-empty.
REQ-012 SHALL have port con_ready  input  1  console sink accepts con_data.

Function
REQ-013 SHALL decode address regions with adr[1:0] ignored: RAM when adr[31:16]==0x0000; MMIO when adr[31:4]==0xFFFF000; otherwise unmapped.
REQ-014 SHALL index RAM with adr[log2(RAM_WORDS)+1:2]; higher RAM-region bits alias (wrap-around).
REQ-015 SHALL drive readdata combinationally in the same cycle as adr, with zero-cycle latency for all regions.
REQ-016 SHALL write writedata to RAM at the rising edge when memwrite=1 and adr is in the RAM region; a read of the same word in that cycle returns the old value.
REQ-017 SHALL implement LED at 0xFFFF0000: read {24'b0,led}; write loads writedata[7:0].
REQ-018 SHALL implement CYCLE at 0xFFFF0004: read-only 32-bit counter incrementing every clk, wrapping 0xFFFFFFFF->0; writes ignored.
REQ-019 SHALL implement CON_TX at 0xFFFF0008: write pushes writedata[7:0]; read returns 0.
REQ-020 SHALL implement CON_STAT at 0xFFFF000C: read {29'b0,overflow,full,empty}; any write clears overflow.
REQ-021 SHALL pop the FIFO head at a rising edge where con_valid=1 and con_ready=1.
REQ-022 SHALL hold con_data and con_valid stable while con_valid=1 and con_ready=0.
REQ-023 SHALL accept a push when full only if a pop occurs in the same edge; count stays FIFO_DEPTH.
REQ-024 SHALL drop a push to a full FIFO without a simultaneous pop and set overflow sticky.
REQ-025 SHALL, on simultaneous push and pop when empty, store the byte and assert con_valid next cycle (no bypass).
REQ-026 SHALL, if overflow set and clear coincide, give clear priority (overflow=0).
REQ-027 SHALL return 0 on reads of unmapped addresses and ignore writes there.

Reset
REQ-028 SHALL on reset set led=0, CYCLE=0, FIFO empty (con_valid=0, con_data=0), overflow=0, immediately and asynchronously.
REQ-029 SHALL NOT reset RAM contents; RAM is preloaded by the bench or an initialization file.
REQ-030 SHALL discard in-flight FIFO contents on reset asserted mid-transfer; no pop is counted.

Structure
REQ-031 SHALL place MMIO address constants, region base/mask constants and the status bit positions in the shared package mips_mem_pkg.
REQ-032 SHALL implement the console FIFO as one sub-module con_fifo (push, pop, data, full, empty, count).

Verification
REQ-033 SHALL cover: store 0xDEADBEEF to 0x00000010, then read 0x00000010 -> 0xDEADBEEF; read 0x00000110 (RAM_WORDS=64) -> 0xDEADBEEF (alias).
REQ-034 SHALL cover: write 0x1A5 to 0xFFFF0000 -> led=0xA5, read -> 0x000000A5; reset -> led=0.
REQ-035 SHALL cover: release reset, read CYCLE after 10 edges -> 10; force counter near 0xFFFFFFFF -> wraps to 0.
REQ-036 SHALL cover: con_ready=0, push 0x41..0x45 -> status reads 0x6 (overflow,full), con_data=0x41; write CON_STAT -> 0x2.
REQ-037 SHALL cover: FIFO full, push 0x50 with con_ready=1 same edge -> accepted, stays full; drain order 0x42,0x43,0x44,0x50.
REQ-038 SHALL cover: read 0x80000000 -> 0; write there -> no RAM, LED or FIFO change.
